ahci_slot_scheduler: RTL and testbench

Parametrised AHCI command-slot scheduler for one port: mirrors PxCI, selects the next pending slot, drives the fetch/execute handshake toward the port command FSM and retires slots on completion. It sits between the register block (software PxCI writes) and the per-port command FSM. It extends the single-command flow with configurable slot count, round-robin or fixed-priority selection, a command watchdog and an error halt.

---
 rtl/ahci_slot_scheduler_pkg.sv | 19 +
 rtl/ahci_slot_scheduler_arbiter.sv | 30 +++
 rtl/ahci_slot_scheduler.sv | 153 +++++++++++++++
 tb/tb_ahci_slot_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahci_slot_scheduler_pkg.sv
// Shared definitions for the AHCI command-slot scheduler: FSM encodings and helpers.
package ahci_slot_scheduler_pkg;

  localparam int unsigned SCHED_ST_W = 3;

  typedef enum logic [SCHED_ST_W-1:0] {
    SCHED_ST_IDLE  = 3'd0,
    SCHED_ST_PICK  = 3'd1,
    SCHED_ST_ISSUE = 3'd2,
    SCHED_ST_WAIT  = 3'd3,
    SCHED_ST_HALT  = 3'd4
  } sched_st_e;

  // A command is owned by the port FSM from the start pulse until completion.
  function automatic logic sched_in_flight(sched_st_e st);
    return (st == SCHED_ST_ISSUE) || (st == SCHED_ST_WAIT);
  endfunction

endpackage

// File: rtl/ahci_slot_scheduler_arbiter.sv
// Combinational rotate-priority finder: first set mask bit at or after start_i, with wrap.
module ahci_slot_arbiter #(
  parameter int unsigned NUM_SLOTS = 32,
  parameter int unsigned SLOT_BITS = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] mask_i,
  input  logic [SLOT_BITS-1:0] start_i,
  input  logic                 rr_mode_i,
  output logic                 found_o,
  output logic [SLOT_BITS-1:0] idx_o
);

  always_comb begin : find
    logic [31:0] base;
    logic [31:0] pos;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    base    = rr_mode_i ? 32'(start_i) : 32'd0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      pos = base + 32'(i);
      if (pos >= 32'(NUM_SLOTS)) pos = pos - 32'(NUM_SLOTS);
      if (!found_o && mask_i[SLOT_BITS'(pos)]) begin
        found_o = 1'b1;
        idx_o   = SLOT_BITS'(pos);
      end
    end
  end

endmodule

// File: rtl/ahci_slot_scheduler.sv
// AHCI per-port command-slot scheduler: PxCI mirror, slot selection, issue/retire
// handshake with the port command FSM, watchdog and error halt.
module ahci_slot_scheduler
  import ahci_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 32,
  parameter int unsigned SLOT_BITS      = $clog2(NUM_SLOTS),
  parameter bit          RR_MODE        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TMR_BITS       = 32
) (
  input  logic                 mclk,
  input  logic                 hba_rst,
  input  logic                 port_st,
  input  logic [NUM_SLOTS-1:0] ci_set,
  output logic [NUM_SLOTS-1:0] ci_pending,
  output logic                 cmd_start,
  output logic [SLOT_BITS-1:0] cmd_slot,
  input  logic                 cmd_done,
  input  logic                 cmd_err,
  output logic                 cmd_abort,
  output logic                 ci_clear,
  output logic                 timeout,
  output logic                 halted
);

  localparam int unsigned CNT_W = TMR_BITS + 1;

  sched_st_e              state_q, state_d;
  logic [NUM_SLOTS-1:0]   pending_q, pending_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [SLOT_BITS-1:0]   last_q, last_d;
  logic [TMR_BITS-1:0]    tmr_q, tmr_d;
  logic                   start_q, start_d;
  logic                   clear_q, clear_d;
  logic                   abort_q, abort_d;
  logic                   tmo_q, tmo_d;
  logic                   halted_q, halted_d;

  logic [SLOT_BITS-1:0]   rr_start;
  logic                   arb_found;
  logic [SLOT_BITS-1:0]   arb_idx;
  logic [CNT_W-1:0]       tmr_inc;
  logic                   tmo_hit;
  logic                   in_wait;
  logic                   done_ok;

  assign rr_start = (last_q == SLOT_BITS'(NUM_SLOTS - 1)) ? '0 : SLOT_BITS'(last_q + SLOT_BITS'(1));

  ahci_slot_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_BITS (SLOT_BITS)
  ) u_arb (
    .mask_i    (pending_q),
    .start_i   (rr_start),
    .rr_mode_i (RR_MODE),
    .found_o   (arb_found),
    .idx_o     (arb_idx)
  );

  // Expiry is decided one cycle early so the registered pulse lands TIMEOUT_CYCLES after cmd_start.
  assign tmr_inc = CNT_W'(tmr_q) + CNT_W'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmr_inc >= (CNT_W'(TIMEOUT_CYCLES) - CNT_W'(1)));
  assign in_wait = (state_q == SCHED_ST_WAIT) && port_st;
  assign done_ok = in_wait && cmd_done && !cmd_err;

  always_ff @(posedge mclk) begin
    if (hba_rst) begin
      state_q   <= SCHED_ST_IDLE;
      pending_q <= '0;
      slot_q    <= '0;
      last_q    <= SLOT_BITS'(NUM_SLOTS - 1);
      tmr_q     <= '0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      last_q    <= last_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      clear_q   <= clear_d;
      abort_q   <= abort_d;
      tmo_q     <= tmo_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!port_st) begin
      state_d = SCHED_ST_IDLE;
    end else begin
      unique case (state_q)
        SCHED_ST_IDLE:  if (pending_d != '0) state_d = SCHED_ST_PICK;
        SCHED_ST_PICK:  state_d = arb_found ? SCHED_ST_ISSUE : SCHED_ST_IDLE;
        SCHED_ST_ISSUE: state_d = SCHED_ST_WAIT;
        SCHED_ST_WAIT: begin
          if (cmd_err)       state_d = SCHED_ST_HALT;
          else if (cmd_done) state_d = SCHED_ST_IDLE;
          else if (tmo_hit)  state_d = SCHED_ST_HALT;
        end
        SCHED_ST_HALT:  state_d = SCHED_ST_HALT;
        default:        state_d = SCHED_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pending_d = port_st ? (pending_q | ci_set) : '0;
    slot_d    = slot_q;
    last_d    = last_q;
    tmr_d     = tmr_q;
    start_d   = 1'b0;
    clear_d   = 1'b0;
    abort_d   = 1'b0;
    tmo_d     = 1'b0;
    halted_d  = (state_d == SCHED_ST_HALT);

    if (done_ok) begin
      pending_d[slot_q] = 1'b0;
      clear_d           = 1'b1;
    end
    if ((state_q == SCHED_ST_PICK) && port_st && arb_found) begin
      slot_d  = arb_idx;
      last_d  = arb_idx;
      start_d = 1'b1;
    end
    if (state_q == SCHED_ST_ISSUE) begin
      tmr_d = '0;
    end else if (state_q == SCHED_ST_WAIT && tmr_q != '1) begin
      tmr_d = tmr_q + TMR_BITS'(1);
    end
    if (in_wait && !cmd_err && !cmd_done && tmo_hit) begin
      tmo_d   = 1'b1;
      abort_d = 1'b1;
    end
    if (!port_st && sched_in_flight(state_q)) abort_d = 1'b1;
  end

  assign ci_pending = pending_q;
  assign cmd_start  = start_q;
  assign cmd_slot   = slot_q;
  assign cmd_abort  = abort_q;
  assign ci_clear   = clear_q;
  assign timeout    = tmo_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_ahci_slot_scheduler.sv
// Bench for ahci_slot_scheduler: a round-robin/timeout instance and a fixed-priority
// instance share stimulus and are checked every cycle against a slot-level model.
module tb_ahci_slot_scheduler;

  localparam int N = 32;
  localparam int M_IDLE = 0, M_PICK = 1, M_ISSUE = 2, M_WAIT = 3, M_HALT = 4;

  logic          mclk = 1'b0;
  logic          hba_rst, port_st, cmd_done, cmd_err;
  logic [N-1:0]  ci_set;

  logic [N-1:0]  rr_pending, fp_pending;
  logic [4:0]    rr_slot, fp_slot;
  logic          rr_start, rr_abort, rr_clear, rr_tmo, rr_halted;
  logic          fp_start, fp_abort, fp_clear, fp_tmo, fp_halted;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  always #5 mclk = ~mclk;

  ahci_slot_scheduler #(.NUM_SLOTS(N), .RR_MODE(1'b1), .TIMEOUT_CYCLES(100)) u_rr (
    .mclk(mclk), .hba_rst(hba_rst), .port_st(port_st), .ci_set(ci_set),
    .ci_pending(rr_pending), .cmd_start(rr_start), .cmd_slot(rr_slot),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_abort(rr_abort),
    .ci_clear(rr_clear), .timeout(rr_tmo), .halted(rr_halted));

  ahci_slot_scheduler #(.NUM_SLOTS(N), .RR_MODE(1'b0), .TIMEOUT_CYCLES(0)) u_fp (
    .mclk(mclk), .hba_rst(hba_rst), .port_st(port_st), .ci_set(ci_set),
    .ci_pending(fp_pending), .cmd_start(fp_start), .cmd_slot(fp_slot),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_abort(fp_abort),
    .ci_clear(fp_clear), .timeout(fp_tmo), .halted(fp_halted));

  // Model state per instance: index 0 = round-robin/timeout 100, index 1 = lowest-first/no watchdog.
  int          m_phase[2];
  logic [31:0] m_pend[2];
  int          m_slot[2], m_last[2], m_start_cyc[2];
  bit          e_start[2], e_clear[2], e_abort[2], e_tmo[2], e_halt[2];

  function automatic int pick(logic [31:0] pend, bit rr, int last);
    if (rr) begin
      for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
    end else begin
      for (int s = 0; s < N; s++) if (pend[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_step(int k, bit rr, int tmo);
    int p;
    logic [31:0] bit_mask;
    e_start[k] = 0; e_clear[k] = 0; e_abort[k] = 0; e_tmo[k] = 0;
    if (hba_rst) begin
      m_phase[k] = M_IDLE; m_pend[k] = 0; m_slot[k] = 0; m_last[k] = N - 1;
    end else if (!port_st) begin
      if (m_phase[k] == M_ISSUE || m_phase[k] == M_WAIT) e_abort[k] = 1;
      m_pend[k] = 0; m_phase[k] = M_IDLE;
    end else begin
      case (m_phase[k])
        M_IDLE: begin
          m_pend[k] |= ci_set;
          if (m_pend[k] != 0) m_phase[k] = M_PICK;
        end
        M_PICK: begin
          p = pick(m_pend[k], rr, m_last[k]);
          m_pend[k] |= ci_set;
          if (p >= 0) begin
            m_slot[k] = p; m_last[k] = p; m_phase[k] = M_ISSUE;
            e_start[k] = 1; m_start_cyc[k] = cyc;
          end else m_phase[k] = M_IDLE;
        end
        M_ISSUE: begin
          m_pend[k] |= ci_set; m_phase[k] = M_WAIT;
        end
        M_WAIT: begin
          bit_mask = 32'd1 << m_slot[k];
          m_pend[k] |= ci_set;
          if (cmd_err) m_phase[k] = M_HALT;
          else if (cmd_done) begin
            m_pend[k] &= ~bit_mask; e_clear[k] = 1; m_phase[k] = M_IDLE;
          end else if (tmo != 0 && (cyc - m_start_cyc[k]) >= tmo) begin
            e_tmo[k] = 1; e_abort[k] = 1; m_phase[k] = M_HALT;
          end
        end
        default: m_pend[k] |= ci_set;
      endcase
    end
    e_halt[k] = (m_phase[k] == M_HALT);
  endtask

  always @(posedge mclk) begin
    cyc++;
    if (hba_rst) armed = 1'b1;
    model_step(0, 1'b1, 100);
    model_step(1, 1'b0, 0);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_inst(string tag, int k, logic [31:0] pend, logic [4:0] slot,
                          bit st, bit ab, bit cl, bit to, bit ha);
    check({tag, ".ci_pending"}, pend, m_pend[k]);
    check({tag, ".cmd_slot"},   32'(slot), m_slot[k]);
    check({tag, ".cmd_start"},  32'(st), 32'(e_start[k]));
    check({tag, ".cmd_abort"},  32'(ab), 32'(e_abort[k]));
    check({tag, ".ci_clear"},   32'(cl), 32'(e_clear[k]));
    check({tag, ".timeout"},    32'(to), 32'(e_tmo[k]));
    check({tag, ".halted"},     32'(ha), 32'(e_halt[k]));
  endtask

  always @(negedge mclk) begin
    if (armed) begin
      cmp_inst("rr", 0, rr_pending, rr_slot, rr_start, rr_abort, rr_clear, rr_tmo, rr_halted);
      cmp_inst("fp", 1, fp_pending, fp_slot, fp_start, fp_abort, fp_clear, fp_tmo, fp_halted);
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rr_start) begin ok = 1'b1; break; end
      tick();
    end
    check("wait_start", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t, s;
    bit ok, found;
    int rr_ord[4], fp_ord[4], st_cyc[4], dn_cyc[4];

    hba_rst = 1; port_st = 0; ci_set = 0; cmd_done = 0; cmd_err = 0;
    repeat (3) tick();
    hba_rst = 0;
    tick();
    check("reset_pending", rr_pending, 32'h0);
    check("reset_slot", 32'(rr_slot), 32'd0);
    check("reset_halted", 32'(rr_halted), 32'd0);
    check("reset_start", 32'(fp_start), 32'd0);
    port_st = 1;
    tick();

    // Single command: start two cycles after the PxCI write, retire one cycle after done.
    ci_set = 32'h1; t = cyc; tick(); ci_set = 0; tick();
    check("t1_start_at_t+2", 32'(cyc - t), 32'd2);
    check("t1_start", 32'(rr_start), 32'd1);
    check("t1_slot", 32'(rr_slot), 32'd0);
    tick(); tick();
    cmd_done = 1; tick(); cmd_done = 0;
    check("t1_clear", 32'(rr_clear), 32'd1);
    check("t1_pending", rr_pending, 32'h0);

    // Fresh reset so round-robin search restarts at slot 0.
    hba_rst = 1; tick(); hba_rst = 0;
    cmd_done = 1; tick(); cmd_done = 0;
    ci_set = 32'h8000_0003; tick(); ci_set = 0;
    for (int n = 0; n < 4; n++) begin
      wait_start(ok);
      rr_ord[n] = int'(rr_slot); fp_ord[n] = int'(fp_slot); st_cyc[n] = cyc;
      if (n == 1) begin
        tick(); ci_set = 32'h1; tick(); ci_set = 0; repeat (3) tick();
      end else repeat (5) tick();
      cmd_done = 1; dn_cyc[n] = cyc; tick(); cmd_done = 0;
    end
    check("rr_order0", 32'(rr_ord[0]), 32'd0);
    check("rr_order1", 32'(rr_ord[1]), 32'd1);
    check("rr_order2", 32'(rr_ord[2]), 32'd31);
    check("rr_order3", 32'(rr_ord[3]), 32'd0);
    check("fp_order0", 32'(fp_ord[0]), 32'd0);
    check("fp_order1", 32'(fp_ord[1]), 32'd1);
    check("fp_order2", 32'(fp_ord[2]), 32'd0);
    check("fp_order3", 32'(fp_ord[3]), 32'd31);
    for (int n = 0; n < 3; n++) check("done_to_next_start", 32'(st_cyc[n+1] - dn_cyc[n]), 32'd3);

    // Watchdog: no completion on slot 5.
    ci_set = 32'h20; t = cyc; tick(); ci_set = 0;
    wait_start(ok); s = cyc;
    check("t3_start_latency", 32'(s - t), 32'd2);
    found = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (rr_tmo) begin found = 1; break; end
    end
    check("t3_timeout_seen", 32'(found), 32'd1);
    check("t3_timeout_delay", 32'(cyc - s), 32'd100);
    check("t3_abort", 32'(rr_abort), 32'd1);
    check("t3_halted", 32'(rr_halted), 32'd1);
    ci_set = 32'h40; tick(); ci_set = 0;
    repeat (5) tick();
    check("t3_rr_pending", rr_pending, 32'h60);
    check("t3_fp_pending", fp_pending, 32'h60);
    port_st = 0; tick(); port_st = 1;
    check("t3_unhalt", 32'(rr_halted), 32'd0);
    check("t3_cleared", rr_pending, 32'h0);
    check("t3_fp_abort", 32'(fp_abort), 32'd1);
    tick(); tick();

    // Error on slot 4 (done in the same cycle loses).
    ci_set = 32'h10; tick(); ci_set = 0;
    repeat (3) tick();
    cmd_err = 1; cmd_done = 1; tick(); cmd_err = 0; cmd_done = 0;
    check("t4_halted", 32'(rr_halted), 32'd1);
    check("t4_pending_kept", rr_pending, 32'h10);
    check("t4_no_clear", 32'(fp_clear), 32'd0);
    repeat (3) tick();
    port_st = 0; tick(); port_st = 1;
    check("t4_stop_pending", fp_pending, 32'h0);
    check("t4_stop_halted", 32'(fp_halted), 32'd0);
    tick();

    // Completion of slot 2 coincides with a PxCI write of slot 7.
    ci_set = 32'h4; tick(); ci_set = 0;
    repeat (3) tick();
    cmd_done = 1; ci_set = 32'h80; tick(); cmd_done = 0; ci_set = 0;
    check("t5_pending", rr_pending, 32'h80);
    check("t5_clear", 32'(rr_clear), 32'd1);
    tick(); tick();
    check("t5_start7", 32'(fp_start), 32'd1);
    check("t5_slot7", 32'(fp_slot), 32'd7);
    tick(); tick();
    cmd_done = 1; tick(); cmd_done = 0;

    // Port stop in WAIT aborts; the simultaneous write is dropped.
    ci_set = 32'h8; tick(); ci_set = 0;
    repeat (3) tick();
    port_st = 0; ci_set = 32'h200; tick(); ci_set = 0; port_st = 1;
    check("t6_abort", 32'(rr_abort), 32'd1);
    check("t6_pending", rr_pending, 32'h0);
    repeat (4) tick();
    check("t6_still_empty", fp_pending, 32'h0);
    check("t6_no_start", 32'(rr_start), 32'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
